multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle sequencer for the CPU datapath. Decodes opcode/funct, steps FETCH->DECODE->EXEC->MEM->WB
//  and drives every datapath enable each cycle. Generates the 4-bit ALU control word; subtract is used
//  for beq. Stalls on a memory ready handshake. Enters a sticky HALT on an illegal opcode or a memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready per access; 0 = wait forever
//  ENABLE_ADDI  1   1 = decode addi (001000); 0 = treat it as illegal
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  synchronous, active-high
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  mem_ready    in   1  memory has completed the current read/write this cycle
//  pcWrite      out  1  unconditional PC load
//  pcWriteCond  out  1  PC load if ALU zero (datapath ANDs with zero)
//  pcSource     out  2  00 ALU, 01 ALUOut, 10 jump target
//  iorD         out  1  0 = PC addresses memory, 1 = ALUOut
//  memRead      out  1  memory read request
//  memWrite     out  1  memory write request
//  irWrite      out  1  latch instruction register
//  memToReg     out  1  1 = write-back data from MDR
//  regDst       out  1  1 = rd, 0 = rt
//  regWrite     out  1  register file write enable
//  aluSrcA      out  1  0 = PC, 1 = A
//  aluSrcB      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  aluCtrl      out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
//  instr_done   out  1  one-cycle pulse on the last cycle of each instruction
//  halted       out  1  sticky; set in HALT state
//  bus_error    out  1  sticky; set when a memory timeout is the cause of HALT
// BEHAVIOUR
//  Reset: state=FETCH, timeout counter=0, halted=bus_error=0; all outputs are Moore-decoded from state.
//  FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluCtrl=add. irWrite and pcWrite are asserted only
//    while mem_ready=1. On that cycle the FSM moves to DECODE; otherwise it holds.
//  DECODE: aluSrcA=0, aluSrcB=11, add (computes branch target).
//    Next state by opcode:
//    000000 -> R_EXEC; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP;
//    001000 -> ADDI_EXEC if ENABLE_ADDI, else HALT; any other opcode -> HALT.
//  R_EXEC: aluSrcA=1, aluSrcB=00, aluCtrl from funct. Then R_WB: regDst=1, memToReg=0, regWrite=1.
//  R_EXEC funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//    Any other funct goes to HALT instead of R_WB.
//  MEM_ADDR: aluSrcA=1, aluSrcB=10, add; then lw -> MEM_READ, sw -> MEM_WRITE.
//  MEM_READ: iorD=1, memRead=1; holds until mem_ready; then LW_WB (regDst=0, memToReg=1, regWrite=1).
//  MEM_WRITE: iorD=1, memWrite=1; holds until mem_ready; then FETCH.
//  BRANCH: aluSrcA=1, aluSrcB=00, sub, pcWriteCond=1, pcSource=01. JUMP: pcWrite=1, pcSource=10.
//  ADDI_EXEC: aluSrcA=1, aluSrcB=10, add; then ADDI_WB: regDst=0, memToReg=0, regWrite=1.
//  Outputs not listed for a state are 0; aluCtrl defaults to 0010.
//  instr_done=1 in R_WB, LW_WB, ADDI_WB, BRANCH and JUMP, and in MEM_WRITE on its mem_ready cycle.
//    All of these return to FETCH.
//  Timeout: counter clears on entry to FETCH/MEM_READ/MEM_WRITE and increments each waiting cycle.
//    If MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT without mem_ready: go to HALT, bus_error=1.
//  HALT: all enables 0, halted=1; only reset exits. mem_ready arriving on the timeout cycle wins (no error).
//  Reset mid-instruction discards the in-flight instruction; all enables are 0 on the next cycle except FETCH's.
// STRUCTURE
//  Shared include cpu_defs.vh: opcode, funct and ALU control localparams, plus the 4-bit state encodings.
//  Sub-module alu_control (combinational): maps {aluOp[1:0], funct[5:0]} to aluCtrl[3:0] and an illegal flag.
//  The FSM instantiates alu_control.
// TESTING
//  Reset held 2 cycles -> state FETCH, memRead=1, all write enables 0, halted=0.
//  add (op 000000, funct 100000), mem_ready tied 1 -> R_WB on 4th cycle, regWrite=1, aluCtrl=0010 in R_EXEC.
//  lw, mem_ready low 3 cycles in MEM_READ -> memRead held 4 cycles, instr_done after 5+3 cycles.
//  beq (000100) -> BRANCH, aluCtrl=0110, pcWriteCond=1, pcSource=01, instr_done=1.
//  opcode 111111 -> HALT after DECODE, halted=1, bus_error=0; stays until reset.
//  MEM_TIMEOUT=4, mem_ready never high in FETCH -> HALT after 4 cycles, bus_error=1.
//  reset asserted during MEM_WRITE -> memWrite=0 next cycle, state=FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle CPU controller: state encodings,
// opcode/funct fields, ALU control words and ALU operation selectors.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_LW_WB     = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_control.sv
// Combinational ALU control decoder: {alu_op, funct} -> 4-bit ALU control word
// plus a flag for an unsupported R-type funct.
module multicycle_control_alu_control
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   illegal  = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer: steps FETCH->DECODE->EXEC->MEM->WB, drives the datapath
// enables, stalls on mem_ready and halts on illegal instructions or memory timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit ENABLE_ADDI = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [1:0] pcSource,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [3:0] aluCtrl,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_error
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        bus_error_q, bus_error_d;
  logic [1:0]  alu_op;
  logic        funct_illegal;
  logic        waiting;

  // ALU operation depends only on the current state, keeping the decoder
  // feedback into next-state logic free of combinational loops.
  always_comb begin
    alu_op = ALUOP_ADD;
    case (state_q)
      S_R_EXEC: alu_op = ALUOP_FUNCT;
      S_BRANCH: alu_op = ALUOP_SUB;
      default:  alu_op = ALUOP_ADD;
    endcase
  end

  multicycle_control_alu_control u_alu_control (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (aluCtrl),
    .illegal  (funct_illegal)
  );

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = 2'b00;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    instr_done  = 1'b0;
    waiting     = 1'b0;
    state_d     = state_q;
    tmo_cnt_d   = 16'd0;
    bus_error_d = bus_error_q;

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = ENABLE_ADDI ? S_ADDI_EXEC : S_HALT;
          default:      state_d = S_HALT;
        endcase
      end
      S_R_EXEC: begin
        aluSrcA = 1'b1;
        state_d = funct_illegal ? S_HALT : S_R_WB;
      end
      S_R_WB: begin
        regDst     = 1'b1;
        regWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        iorD    = 1'b1;
        memRead = 1'b1;
        if (mem_ready) state_d = S_LW_WB;
        else           waiting = 1'b1;
      end
      S_MEM_WRITE: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      S_LW_WB: begin
        memToReg   = 1'b1;
        regWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pcWrite    = 1'b1;
        pcSource   = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        regWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Counter is zero on every state change, so it restarts on each access.
    if (waiting && (MEM_TIMEOUT != 0)) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
      if (tmo_cnt_d == TIMEOUT_LIMIT) begin
        state_d     = S_HALT;
        bus_error_d = 1'b1;
        tmo_cnt_d   = 16'd0;
      end
    end
  end

  assign halted    = (state_q == S_HALT);
  assign bus_error = bus_error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      tmo_cnt_q   <= 16'd0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle pushes the expected output
// vector for the intended state, then pops and compares it mid-cycle.
module tb_multicycle_control;

  localparam int E_FETCH = 0, E_DECODE = 1, E_REXEC = 2, E_RWB = 3, E_MADDR = 4,
                 E_MREAD = 5, E_MWRITE = 6, E_LWWB = 7, E_BR = 8, E_JMP = 9,
                 E_AEXEC = 10, E_AWB = 11, E_HALT = 12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_BAD = 6'b111111;
  localparam logic [3:0] C_ADD = 4'b0010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, instr_done, halted, bus_error;
  logic [1:0] pcSource, aluSrcB;
  logic [3:0] aluCtrl;

  multicycle_control #(.MEM_TIMEOUT(4), .ENABLE_ADDI(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg),
    .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluCtrl(aluCtrl), .instr_done(instr_done), .halted(halted), .bus_error(bus_error)
  );

  logic [20:0] obs;
  assign obs = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite, memToReg,
                regDst, regWrite, aluSrcA, aluSrcB, aluCtrl, instr_done, halted, bus_error};

  typedef struct {
    string       tag;
    logic [20:0] vec;
  } exp_t;
  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [20:0] exp_vec(input int st, input logic mr,
                                          input logic [3:0] rctl, input logic be);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
    logic rdst = 0, rw = 0, asa = 0, done = 0, hlt = 0, berr = 0;
    logic [1:0] psrc = 2'b00, asb = 2'b00;
    logic [3:0] ac = C_ADD;
    case (st)
      E_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      E_DECODE: asb = 2'b11;
      E_REXEC:  begin asa = 1; ac = rctl; end
      E_RWB:    begin rdst = 1; rw = 1; done = 1; end
      E_MADDR:  begin asa = 1; asb = 2'b10; end
      E_MREAD:  begin iord = 1; mrd = 1; end
      E_MWRITE: begin iord = 1; mwr = 1; done = mr; end
      E_LWWB:   begin m2r = 1; rw = 1; done = 1; end
      E_BR:     begin asa = 1; ac = 4'b0110; pcwc = 1; psrc = 2'b01; done = 1; end
      E_JMP:    begin pcw = 1; psrc = 2'b10; done = 1; end
      E_AEXEC:  begin asa = 1; asb = 2'b10; end
      E_AWB:    begin rw = 1; done = 1; end
      E_HALT:   begin hlt = 1; berr = be; end
      default:  ;
    endcase
    return {pcw, pcwc, psrc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, ac, done, hlt, berr};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic mr, input int st,
                      input logic [3:0] rctl, input logic be);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    funct     = fn;
    mem_ready = mr;
    e.tag = tag;
    e.vec = exp_vec(st, mr, rctl, be);
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    assert (obs === e.vec)
      else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
      end
    $display("step %s: outputs %b", e.tag, obs);
  endtask

  task automatic run_r(input string nm, input logic [5:0] fn, input logic [3:0] rctl);
    step({nm, "_fetch"},  0, OP_R, fn, 1, E_FETCH,  C_ADD, 0);
    step({nm, "_decode"}, 0, OP_R, fn, 1, E_DECODE, C_ADD, 0);
    step({nm, "_exec"},   0, OP_R, fn, 1, E_REXEC,  rctl,  0);
    step({nm, "_wb"},     0, OP_R, fn, 1, E_RWB,    C_ADD, 0);
  endtask

  logic [5:0] r_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0] r_ct [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
  string      r_nm [5] = '{"add", "sub", "and", "or", "slt"};

  initial begin
    step("reset0", 1, OP_R, 6'd0, 0, E_FETCH, C_ADD, 0);
    step("reset1", 1, OP_R, 6'd0, 0, E_FETCH, C_ADD, 0);

    for (int i = 0; i < 5; i++) run_r(r_nm[i], r_fn[i], r_ct[i]);

    step("lw_fetch", 0, OP_LW, 6'd0, 1, E_FETCH, C_ADD, 0);
    step("lw_decode", 0, OP_LW, 6'd0, 0, E_DECODE, C_ADD, 0);
    step("lw_addr", 0, OP_LW, 6'd0, 0, E_MADDR, C_ADD, 0);
    for (int i = 0; i < 3; i++) step("lw_wait", 0, OP_LW, 6'd0, 0, E_MREAD, C_ADD, 0);
    step("lw_ready", 0, OP_LW, 6'd0, 1, E_MREAD, C_ADD, 0);
    step("lw_wb", 0, OP_LW, 6'd0, 0, E_LWWB, C_ADD, 0);

    step("sw_fetch", 0, OP_SW, 6'd0, 1, E_FETCH, C_ADD, 0);
    step("sw_decode", 0, OP_SW, 6'd0, 0, E_DECODE, C_ADD, 0);
    step("sw_addr", 0, OP_SW, 6'd0, 0, E_MADDR, C_ADD, 0);
    step("sw_wait", 0, OP_SW, 6'd0, 0, E_MWRITE, C_ADD, 0);
    step("sw_ready", 0, OP_SW, 6'd0, 1, E_MWRITE, C_ADD, 0);

    step("beq_fetch", 0, OP_BEQ, 6'd0, 1, E_FETCH, C_ADD, 0);
    step("beq_decode", 0, OP_BEQ, 6'd0, 1, E_DECODE, C_ADD, 0);
    step("beq_branch", 0, OP_BEQ, 6'd0, 1, E_BR, C_ADD, 0);

    // mem_ready arriving on the would-be timeout cycle must win.
    for (int i = 0; i < 3; i++) step("j_fetch_wait", 0, OP_J, 6'd0, 0, E_FETCH, C_ADD, 0);
    step("j_fetch_ready", 0, OP_J, 6'd0, 1, E_FETCH, C_ADD, 0);
    step("j_decode", 0, OP_J, 6'd0, 0, E_DECODE, C_ADD, 0);
    step("j_jump", 0, OP_J, 6'd0, 0, E_JMP, C_ADD, 0);

    step("addi_fetch", 0, OP_ADDI, 6'd0, 1, E_FETCH, C_ADD, 0);
    step("addi_decode", 0, OP_ADDI, 6'd0, 1, E_DECODE, C_ADD, 0);
    step("addi_exec", 0, OP_ADDI, 6'd0, 1, E_AEXEC, C_ADD, 0);
    step("addi_wb", 0, OP_ADDI, 6'd0, 1, E_AWB, C_ADD, 0);

    step("badfn_fetch", 0, OP_R, 6'b000111, 1, E_FETCH, C_ADD, 0);
    step("badfn_decode", 0, OP_R, 6'b000111, 0, E_DECODE, C_ADD, 0);
    step("badfn_exec", 0, OP_R, 6'b000111, 0, E_REXEC, C_ADD, 0);
    step("badfn_halt0", 0, OP_R, 6'b000111, 0, E_HALT, C_ADD, 0);
    step("badfn_halt1", 0, OP_R, 6'b000111, 1, E_HALT, C_ADD, 0);
    step("badfn_rst", 1, OP_R, 6'd0, 0, E_HALT, C_ADD, 0);

    step("badop_fetch", 0, OP_BAD, 6'd0, 1, E_FETCH, C_ADD, 0);
    step("badop_decode", 0, OP_BAD, 6'd0, 1, E_DECODE, C_ADD, 0);
    for (int i = 0; i < 3; i++)
      step("badop_halt", 0, OP_BAD, 6'd0, 1'(i), E_HALT, C_ADD, 0);
    step("badop_rst", 1, OP_R, 6'd0, 0, E_HALT, C_ADD, 0);

    for (int i = 0; i < 4; i++) step("tmo_fetch", 0, OP_R, 6'd0, 0, E_FETCH, C_ADD, 0);
    step("tmo_halt0", 0, OP_R, 6'd0, 0, E_HALT, C_ADD, 1);
    step("tmo_halt1", 0, OP_R, 6'd0, 1, E_HALT, C_ADD, 1);
    step("tmo_rst", 1, OP_R, 6'd0, 0, E_HALT, C_ADD, 1);
    step("tmo_cleared", 0, OP_SW, 6'd0, 1, E_FETCH, C_ADD, 0);

    step("swrst_decode", 0, OP_SW, 6'd0, 0, E_DECODE, C_ADD, 0);
    step("swrst_addr", 0, OP_SW, 6'd0, 0, E_MADDR, C_ADD, 0);
    step("swrst_write", 1, OP_SW, 6'd0, 0, E_MWRITE, C_ADD, 0);
    step("swrst_fetch", 0, OP_SW, 6'd0, 0, E_FETCH, C_ADD, 0);
    step("post_fetch", 0, OP_R, 6'b100010, 1, E_FETCH, C_ADD, 0);
    step("post_decode", 0, OP_R, 6'b100010, 0, E_DECODE, C_ADD, 0);
    step("post_exec", 0, OP_R, 6'b100010, 0, E_REXEC, 4'b0110, 0);
    step("post_wb", 0, OP_R, 6'b100010, 0, E_RWB, C_ADD, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
